// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencer and the serial multiplier it drives.
package mac_ctrl_pkg;

  localparam int MUL_OP_W  = 8;
  localparam int MUL_RES_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    ACC     = 3'd4,
    OUT     = 3'd5
  } state_t;

endpackage

// File: rtl/mac_acc.sv
// Wide accumulator with saturating beat counter and sticky wrap flag.
module mac_acc
  import mac_ctrl_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 add,
  input  logic                 clear,
  input  logic [MUL_RES_W-1:0] addend,
  output logic [ACC_W-1:0]     acc,
  output logic [7:0]           count,
  output logic                 ovf
);

  // The extra top bit of the sum is the carry out of the accumulator.
  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + (ACC_W + 1)'(addend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (add) begin
      acc   <= sum[ACC_W-1:0];
      count <= (count == 8'hFF) ? count : count + 8'd1;
      ovf   <= ovf | sum[ACC_W];
    end
  end

endmodule

// File: rtl/mac_ctrl.sv
// Feeds operand beats to the serial multiplier one at a time and accumulates
// the products, presenting the vector sum when the last beat completes.
module mac_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ACC_W      = 24,
  parameter int HI_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MUL_OP_W-1:0]  in_a,
  input  logic [MUL_OP_W-1:0]  in_b,
  input  logic                 in_last,
  output logic [MUL_OP_W-1:0]  mul_a,
  output logic [MUL_OP_W-1:0]  mul_b,
  output logic                 mul_start,
  input  logic                 mul_busy,
  input  logic [MUL_RES_W-1:0] mul_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic [7:0]           out_count,
  output logic                 out_ovf,
  output logic                 err
);

  localparam int TMR_W = $clog2(HI_TIMEOUT + 1);

  state_t             state;
  logic [TMR_W-1:0]   hi_tmr;
  logic               last_q;
  logic               skip_add;
  logic               acc_add;
  logic               acc_clear;
  logic [MUL_RES_W-1:0] addend;

  assign acc_add   = (state == ACC);
  assign acc_clear = (state == OUT) && out_ready;
  // A beat whose multiply never started contributes nothing to the sum.
  assign addend    = skip_add ? '0 : mul_result;

  mac_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .add    (acc_add),
    .clear  (acc_clear),
    .addend (addend),
    .acc    (out_acc),
    .count  (out_count),
    .ovf    (out_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hi_tmr    <= '0;
      last_q    <= 1'b0;
      skip_add  <= 1'b0;
      in_ready  <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
            state     <= START;
          end else begin
            in_ready <= 1'b1;
          end
        end
        START: begin
          mul_start <= 1'b0;
          hi_tmr    <= '0;
          skip_add  <= 1'b0;
          state     <= WAIT_HI;
        end
        // Busy rising is checked first so it beats a coincident timeout.
        WAIT_HI: begin
          if (mul_busy) begin
            state <= WAIT_LO;
          end else if (hi_tmr == TMR_W'(HI_TIMEOUT - 1)) begin
            err      <= 1'b1;
            skip_add <= 1'b1;
            state    <= ACC;
          end else begin
            hi_tmr <= hi_tmr + TMR_W'(1);
          end
        end
        WAIT_LO: begin
          if (!mul_busy) state <= ACC;
        end
        ACC: begin
          if (last_q) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed bench for mac_ctrl with a behavioural serial multiplier model;
// a second instance with a 16-bit accumulator exercises wrap-around.
module tb_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        mul_busy;
  logic [15:0] mul_result;

  logic        in_ready, mul_start, out_valid, out_ovf, err;
  logic [7:0]  mul_a, mul_b, out_count;
  logic [23:0] out_acc;

  logic        in_ready16, mul_start16, out_valid16, out_ovf16, err16;
  logic [7:0]  mul_a16, mul_b16, out_count16;
  logic [15:0] out_acc16;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int mul_lat = 3;
  logic mul_dead = 1'b0;
  int lat_cnt;
  logic [15:0] prod_q;

  always #5 clk = ~clk;

  mac_ctrl #(.ACC_W(24), .HI_TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf), .err(err)
  );

  mac_ctrl #(.ACC_W(16), .HI_TIMEOUT(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_start(mul_start16),
    .mul_busy(mul_busy), .mul_result(mul_result),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .out_count(out_count16), .out_ovf(out_ovf16), .err(err16)
  );

  // Serial multiplier stand-in: busy for mul_lat cycles, product valid at fall.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_busy   <= 1'b0;
      mul_result <= '0;
      lat_cnt    <= 0;
      prod_q     <= '0;
    end else if (mul_start && !mul_dead) begin
      mul_busy <= 1'b1;
      lat_cnt  <= mul_lat;
      prod_q   <= 16'(mul_a) * 16'(mul_b);
    end else if (mul_busy) begin
      if (lat_cnt == 1) begin
        mul_busy   <= 1'b0;
        mul_result <= prod_q;
      end
      lat_cnt <= lat_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (mul_start) start_cnt <= start_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic bound_expired(input string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) bound_expired("send_beat");
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_expired("wait_out");
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s0;
    int n;
    bit ok;

    #12;
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_acc", out_acc, 0);
    check_output("rst_mul_start", mul_start, 0);
    check_output("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("idle_in_ready", in_ready, 1);

    // Single beat 12*10.
    s0 = start_cnt;
    send_beat(8'd12, 8'd10, 1'b1);
    wait_out();
    check_output("t1_acc", out_acc, 120);
    check_output("t1_count", out_count, 1);
    check_output("t1_ovf", out_ovf, 0);
    check_output("t1_in_ready", in_ready, 0);
    check_output("t1_mul_a", mul_a, 12);
    check_output("t1_mul_b", mul_b, 10);
    check_output("t1_starts", start_cnt - s0, 1);
    consume();
    check_output("t1_cleared_valid", out_valid, 0);
    check_output("t1_cleared_acc", out_acc, 0);
    check_output("t1_after_in_ready", in_ready, 1);
    check_output("t1_mul_a_held", mul_a, 12);

    // Three-beat vector then a fresh single beat.
    s0 = start_cnt;
    send_beat(8'd3, 8'd4, 1'b0);
    send_beat(8'd5, 8'd6, 1'b0);
    send_beat(8'd255, 8'd255, 1'b1);
    wait_out();
    check_output("t2_acc", out_acc, 65067);
    check_output("t2_count", out_count, 3);
    check_output("t2_ovf", out_ovf, 0);
    check_output("t2_starts", start_cnt - s0, 3);
    check_output("t2_acc16", out_acc16, 65067);
    check_output("t2_ovf16", out_ovf16, 0);
    consume();
    send_beat(8'd2, 8'd2, 1'b1);
    wait_out();
    check_output("t2b_acc", out_acc, 4);
    check_output("t2b_count", out_count, 1);
    consume();

    // Two max products: wraps only in the 16-bit instance.
    send_beat(8'd255, 8'd255, 1'b0);
    send_beat(8'd255, 8'd255, 1'b1);
    wait_out();
    check_output("t3_acc24", out_acc, 130050);
    check_output("t3_ovf24", out_ovf, 0);
    check_output("t3_acc16", out_acc16, 64514);
    check_output("t3_ovf16", out_ovf16, 1);
    check_output("t3_count16", out_count16, 2);

    // Back-pressure on the result with a beat waiting at the input.
    s0 = start_cnt;
    in_a = 8'd1;
    in_b = 8'd1;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("hold_valid", out_valid, 1);
      check_output("hold_acc", out_acc, 130050);
      check_output("hold_in_ready", in_ready, 0);
      check_output("hold_mul_start", mul_start, 0);
    end
    check_output("hold_starts", start_cnt - s0, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_output("rel_valid", out_valid, 0);
    check_output("rel_in_ready", in_ready, 1);
    @(negedge clk);
    check_output("rel_next_start", mul_start, 1);
    check_output("rel_next_in_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_out();
    check_output("rel_acc", out_acc, 1);
    check_output("rel_count", out_count, 1);
    consume();

    // Multiplier never answers: timeout after four cycles in WAIT_HI.
    check_output("to_err_before", err, 0);
    mul_dead = 1'b1;
    send_beat(8'd7, 8'd7, 1'b1);
    n = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (err) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_expired("to_err_rise");
    // One START cycle, four WAIT_HI cycles, sampled on the following negedge.
    check_output("to_err_delay", n, 6);
    wait_out();
    check_output("to_acc", out_acc, 0);
    check_output("to_count", out_count, 1);
    check_output("to_valid", out_valid, 1);
    consume();
    check_output("to_err_sticky", err, 1);
    mul_dead = 1'b0;

    // Reset while the multiplier is busy.
    mul_lat = 6;
    send_beat(8'd200, 8'd200, 1'b1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_expired("rw_busy_rise");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rw_in_ready", in_ready, 0);
    check_output("rw_mul_a", mul_a, 0);
    check_output("rw_mul_start", mul_start, 0);
    check_output("rw_out_valid", out_valid, 0);
    check_output("rw_out_acc", out_acc, 0);
    check_output("rw_out_count", out_count, 0);
    check_output("rw_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    mul_lat = 3;
    send_beat(8'd9, 8'd9, 1'b1);
    wait_out();
    check_output("rw_after_acc", out_acc, 81);
    check_output("rw_after_count", out_count, 1);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_ctrl.md
Name: mac_ctrl

Overview:
- Sequencer directly upstream of the serial 8x8 multiplier (mul); feeds operand pairs to it and consumes its 16-bit product.
- Accepts a stream of (a, b, last) beats on a valid/ready handshake.
- Runs one mul operation per beat and accumulates the products into a wide sum.
- Emits the sum, the beat count and an overflow flag on a valid/ready output when the beat tagged last completes; used for dot products in the datapath top.

Parameters:
- ACC_W, 24, accumulator/output width; legal range 16..32.
- HI_TIMEOUT, 4, maximum cycles to wait for mul_busy to rise after mul_start before flagging an error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- in_last  in  1  final beat of the current vector.
- mul_a  out  8  operand A to mul.
- mul_b  out  8  operand B to mul.
- mul_start  out  1  one-cycle start pulse to mul.
- mul_busy  in  1  mul busy; rises on the cycle after an accepted start.
- mul_result  in  16  mul product; valid once mul_busy has fallen.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  accumulated sum of products.
- out_count  out  8  number of beats in the vector; saturates at 255.
- out_ovf  out  1  accumulator wrapped during the vector.
- err  out  1  sticky error: mul_busy failed to rise within HI_TIMEOUT; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. in_ready=0 during reset, then 1 in IDLE. mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0, err=0. Internal accumulator, count, ovf and last flag = 0.
- Reset mid-operation: abandon everything immediately. The integration top also resets mul on the same event.
- All outputs are registered. mul_a and mul_b hold their value from launch until the next beat is accepted.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch in_a/in_b into mul_a/mul_b, latch in_last, go to START.
  - START: mul_start=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_HI.
  - WAIT_HI: on mul_busy=1, go to WAIT_LO. If the timeout counter reaches HI_TIMEOUT, set err=1, add 0 for this beat and go to ACC.
  - WAIT_LO: on mul_busy=0, go to ACC. There is no timeout in this state.
  - ACC: acc <= acc + zero-extended mul_result (result sampled this cycle). Overflow is a carry out of bit ACC_W-1: the sum wraps modulo 2^ACC_W and ovf is set (sticky). count <= min(count+1, 255). If the last flag is set, go to OUT, else go to IDLE.
  - OUT: out_valid=1, with out_acc/out_count/out_ovf held stable. On out_ready=1: clear acc/count/ovf and go to IDLE. in_ready=0 throughout.
- in_ready=1 only in IDLE. A beat is taken only on in_valid&&in_ready.
- Throughput: at most one beat per (mul latency + 4) cycles. No overlap with mul.
- Beat-to-out_valid latency for a single last beat: 4 cycles + mul busy duration.
- out_valid and outputs are held until the handshake completes, whatever out_ready does.
- Simultaneous mul_busy rise and timeout expiry in WAIT_HI: the busy rise wins, no err.
- Empty vector cannot occur: every vector contains at least one beat.

Decomposition:
- Shared package: state encoding localparams (IDLE, START, WAIT_HI, WAIT_LO, ACC, OUT) and MUL_OP_W=8 / MUL_RES_W=16 width constants, shared with mul.
- One sub-module: mac_acc, which holds the accumulator, count and ovf registers, takes add/clear strobes, and owns the wide adder. The FSM stays in mac_ctrl.

Test Plan:
- Single beat a=12, b=10, last=1 -> exactly one mul_start pulse, mul_a=12, mul_b=10; out_valid with out_acc=120, out_count=1, out_ovf=0; in_ready=0 until out_ready.
- Vector (3,4),(5,6),(255,255,last) -> three mul_start pulses, out_acc=12+30+65025=65067, out_count=3; acc cleared, and a following single beat (2,2,last) yields 4.
- With ACC_W=16, vector (255,255),(255,255,last) -> out_acc=(130050 mod 65536)=64514, out_ovf=1.
- Bench mul model never raises busy, beat (7,7,last) -> err=1 after HI_TIMEOUT=4 cycles in WAIT_HI; out_acc=0, out_count=1, out_valid=1.
- Hold out_ready=0 for 20 cycles with in_valid=1 -> out_* stable, in_ready=0, no mul_start; release -> handshake completes, next beat is accepted the cycle after.
- Assert rst=0 while in WAIT_LO -> all outputs return to reset values within the same cycle; after release, a fresh beat (9,9,last) gives out_acc=81, out_count=1.
